// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : data_mem_ctrl_if
// Core-side request/response bus of the data memory controller.
// Revision  : 1.0
// ============================================================================
interface data_mem_ctrl_if;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic        busy;

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, done, err, rdata, busy
   );

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, done, err, rdata, busy
   );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Load/store controller in front of a word RAM with a registered read port;
// sub-word stores are done as read-modify-write.
// Option   : DMEM_MISALIGN_TRAP_EN traps misaligned half/word accesses.
// Revision : 1.0
// ============================================================================
module data_mem_ctrl #(
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned RESP_HOLD = 1
) (
   input  logic              clk,
   input  logic              nRst,
   data_mem_ctrl_if.slave    bus,
   output logic              write_enable,
   output logic              read_enable,
   output logic [ADDR_W-1:0] address_DM,
   output logic [31:0]       data_in,
   input  logic [31:0]       data_out
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_BAD  = 2'b11;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      MRG  = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              write_q, write_d;
   logic              uns_q, uns_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              we_q, we_d;
   logic              re_q, re_d;
   logic [31:0]       rhold_q, rhold_d;

   logic [ADDR_W-1:0] req_addr_masked;
   logic              misalign;
   logic              bad_req;
   logic [7:0]        lane_byte;
   logic [15:0]       lane_half;
   logic [31:0]       load_fmt;
   logic [31:0]       merge_word;
   logic              unused_addr_bits;

   // Upper address bits wrap inside the RAM.
   assign unused_addr_bits = ^bus.req_addr[31:ADDR_W];

`ifdef DMEM_MISALIGN_TRAP_EN
   assign misalign = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                     ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign bad_req = (bus.req_size == SZ_BAD) || misalign;

   always_comb begin
      req_addr_masked = bus.req_addr[ADDR_W-1:0];
      if (bus.req_size == SZ_HALF) begin
         req_addr_masked[0] = 1'b0;
      end else if (bus.req_size == SZ_WORD) begin
         req_addr_masked[1:0] = 2'b00;
      end
   end

   // Lane extraction and merge work on the RAM word returned this cycle.
   always_comb begin
      lane_byte = data_out[{addr_q[1:0], 3'b000} +: 8];
      lane_half = addr_q[1] ? data_out[31:16] : data_out[15:0];
      case (size_q)
         SZ_BYTE: load_fmt = {{24{lane_byte[7] & ~uns_q}}, lane_byte};
         SZ_HALF: load_fmt = {{16{lane_half[15] & ~uns_q}}, lane_half};
         default: load_fmt = data_out;
      endcase
      merge_word = data_out;
      if (size_q == SZ_BYTE) begin
         merge_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end else if (addr_q[1]) begin
         merge_word[31:16] = wdata_q[15:0];
      end else begin
         merge_word[15:0] = wdata_q[15:0];
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      size_d  = size_q;
      write_d = write_q;
      uns_d   = uns_q;
      wdata_d = wdata_q;
      rhold_d = rhold_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      we_d    = 1'b0;
      re_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d  = req_addr_masked;
               size_d  = bus.req_size;
               write_d = bus.req_write;
               uns_d   = bus.req_unsigned;
               wdata_d = bus.req_wdata;
               if (bad_req) begin
                  state_d = RESP;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else if (bus.req_write && (bus.req_size == SZ_WORD)) begin
                  state_d = WR;
                  we_d    = 1'b1;
               end else begin
                  state_d = RD;
                  re_d    = 1'b1;
               end
            end
         end
         RD: begin
            if (write_q) begin
               state_d = MRG;
               we_d    = 1'b1;
            end else begin
               state_d = RESP;
               done_d  = 1'b1;
            end
         end
         MRG, WR: begin
            state_d = RESP;
            done_d  = 1'b1;
         end
         RESP: begin
            state_d = IDLE;
            if (!write_q && !err_q) begin
               rhold_d = load_fmt;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         size_q  <= 2'b00;
         write_q <= 1'b0;
         uns_q   <= 1'b0;
         wdata_q <= 32'h0;
         rhold_q <= 32'h0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         write_q <= write_d;
         uns_q   <= uns_d;
         wdata_q <= wdata_d;
         rhold_q <= rhold_d;
         done_q  <= done_d;
         err_q   <= err_d;
         we_q    <= we_d;
         re_q    <= re_d;
      end
   end

   assign write_enable  = we_q;
   assign read_enable   = re_q;
   assign address_DM    = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus.req_ready = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.err       = err_q;

   always_comb begin
      case (state_q)
         WR:      data_in = wdata_q;
         MRG:     data_in = merge_word;
         default: data_in = 32'h0;
      endcase
   end

   // The load result is only live in RESP; outside it rdata holds or reads zero.
   always_comb begin
      if ((state_q == RESP) && !write_q && !err_q) begin
         bus.rdata = load_fmt;
      end else if (RESP_HOLD != 0) begin
         bus.rdata = rhold_q;
      end else begin
         bus.rdata = 32'h0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Self-checking bench for data_mem_ctrl: directed vector table, reset abort
// sequence and randomized traffic against a word-array reference model.
// Revision : 1.0
// ============================================================================
module tb_data_mem_ctrl;

   logic        clk;
   logic        nRst;
   logic        write_enable;
   logic        read_enable;
   logic [5:0]  address_DM;
   logic [31:0] data_in;
   logic [31:0] data_out;

   data_mem_ctrl_if bus ();

   data_mem_ctrl #(.ADDR_W(6), .RESP_HOLD(1)) dut (
      .clk          (clk),
      .nRst         (nRst),
      .bus          (bus),
      .write_enable (write_enable),
      .read_enable  (read_enable),
      .address_DM   (address_DM),
      .data_in      (data_in),
      .data_out     (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word RAM with registered read; the poke port preloads contents.
   logic [31:0] mem [16];
   logic        poke_en;
   logic [3:0]  poke_idx;
   logic [31:0] poke_val;

   always @(posedge clk) begin
      if (poke_en) mem[poke_idx] <= poke_val;
      else if (write_enable) mem[address_DM[5:2]] <= data_in;
      if (read_enable) data_out <= mem[address_DM[5:2]];
   end

   int both_hi  = 0;
   int dbl_done = 0;
   int done_cnt = 0;
   logic done_prev = 1'b0;

   always @(negedge clk) begin
      if (write_enable && read_enable) both_hi <= both_hi + 1;
      if (done_prev && bus.done) dbl_done <= dbl_done + 1;
      if (bus.done) done_cnt <= done_cnt + 1;
      done_prev <= bus.done;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
      end
   endtask

   task automatic poke(input int idx, input logic [31:0] val);
      @(negedge clk);
      poke_en  = 1'b1;
      poke_idx = idx[3:0];
      poke_val = val;
      @(negedge clk);
      poke_en  = 1'b0;
   endtask

   task automatic run_txn(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic drop,
                          output int lat, output logic [31:0] rd, output logic e,
                          output logic [31:0] din, output int n_we, output int n_re);
      lat = -1; rd = 32'h0; e = 1'b0; din = 32'h0; n_we = 0; n_re = 0;
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("idle_ready", 0, {31'b0, bus.req_ready}, 32'd1);
      bus.req_valid    = 1'b1;
      bus.req_write    = wr;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wd;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (drop) begin
            bus.req_valid = 1'b0;
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
            bus.req_size  = 2'($urandom_range(0, 3));
         end
         if (write_enable) begin
            n_we++;
            din = data_in;
         end
         if (read_enable) n_re++;
         if (bus.done) begin
            lat = k;
            rd  = bus.rdata;
            e   = bus.err;
            break;
         end
      end
      bus.req_valid = 1'b0;
   endtask

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      int          lat;
      logic        err;
      logic [31:0] rd;
      logic        chk_rd;
      logic [31:0] din;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                      input logic [31:0] wd, input int lat, input logic err, input logic [31:0] rd,
                      input logic chk_rd, input logic [31:0] din);
      vec_t v;
      v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd;
      v.lat = lat; v.err = err; v.rd = rd; v.chk_rd = chk_rd; v.din = din;
      tbl.push_back(v);
   endtask

   logic [31:0] ref_mem [16];
   logic [31:0] last_load;

   initial begin
      int          lat, n_we, n_re, elat, dc;
      logic [31:0] rd, din, erd, w, v, m, addr, wd;
      logic        e, eerr, wr, uns, bad, drop;
      logic [1:0]  sz;
      logic [5:0]  a;
      int unsigned sh;

      nRst = 1'b0;
      poke_en = 1'b0; poke_idx = 4'd0; poke_val = 32'h0;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

      #2;
      check("rst_done", 0, {31'b0, bus.done}, 32'd0);
      check("rst_err", 0, {31'b0, bus.err}, 32'd0);
      check("rst_strobes", 0, {30'b0, write_enable, read_enable}, 32'd0);
      check("rst_data_in", 0, data_in, 32'h0);
      check("rst_addr", 0, {26'b0, address_DM}, 32'h0);
      check("rst_rdata", 0, bus.rdata, 32'h0);
      check("rst_busy", 0, {31'b0, bus.busy}, 32'd0);
      @(negedge clk);
      nRst = 1'b1;

      poke(0, 32'h00000000);
      poke(1, 32'h55667788);
      poke(2, 32'h11223344);
      poke(3, 32'h8899AABB);

      //  wr    sz     uns   addr           wdata          lat err  rdata          chk   data_in
      add(1'b0, 2'b00, 1'b0, 32'h0000000D, 32'h0,        2, 1'b0, 32'hFFFFFFAA, 1'b1, 32'h0);
      add(1'b0, 2'b00, 1'b1, 32'h0000000D, 32'h0,        2, 1'b0, 32'h000000AA, 1'b1, 32'h0);
      add(1'b1, 2'b00, 1'b0, 32'h0000000A, 32'h000000EE, 3, 1'b0, 32'h0,        1'b0, 32'h11EE3344);
      add(1'b0, 2'b10, 1'b0, 32'h00000008, 32'h0,        2, 1'b0, 32'h11EE3344, 1'b1, 32'h0);
      add(1'b1, 2'b10, 1'b0, 32'h0000000C, 32'hDEADBEEF, 2, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF);
      add(1'b0, 2'b10, 1'b1, 32'h0000000C, 32'h0,        2, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0);
      add(1'b1, 2'b10, 1'b0, 32'h0000000C, 32'h80010000, 2, 1'b0, 32'h0,        1'b0, 32'h80010000);
      add(1'b0, 2'b01, 1'b0, 32'h0000000E, 32'h0,        2, 1'b0, 32'hFFFF8001, 1'b1, 32'h0);
      add(1'b0, 2'b01, 1'b1, 32'h0000000E, 32'h0,        2, 1'b0, 32'h00008001, 1'b1, 32'h0);
      add(1'b0, 2'b11, 1'b0, 32'h00000004, 32'h0,        1, 1'b1, 32'h00008001, 1'b1, 32'h0);
      add(1'b0, 2'b01, 1'b0, 32'h0000000C, 32'h0,        2, 1'b0, 32'h00000000, 1'b1, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
      add(1'b0, 2'b10, 1'b0, 32'h00000006, 32'h0,        1, 1'b1, 32'h00000000, 1'b1, 32'h0);
      add(1'b1, 2'b01, 1'b0, 32'h00000007, 32'h1234ABCD, 1, 1'b1, 32'h0,        1'b0, 32'h0);
      add(1'b0, 2'b00, 1'b0, 32'h00000047, 32'h0,        2, 1'b0, 32'h00000055, 1'b1, 32'h0);
`else
      add(1'b0, 2'b10, 1'b0, 32'h00000006, 32'h0,        2, 1'b0, 32'h55667788, 1'b1, 32'h0);
      add(1'b1, 2'b01, 1'b0, 32'h00000007, 32'h1234ABCD, 3, 1'b0, 32'h0,        1'b0, 32'hABCD7788);
      add(1'b0, 2'b00, 1'b0, 32'h00000047, 32'h0,        2, 1'b0, 32'hFFFFFFAB, 1'b1, 32'h0);
`endif
      add(1'b1, 2'b00, 1'b0, 32'h00000100, 32'h12345677, 3, 1'b0, 32'h0,        1'b0, 32'h00000077);
      add(1'b0, 2'b00, 1'b1, 32'h00000000, 32'h0,        2, 1'b0, 32'h00000077, 1'b1, 32'h0);
      add(1'b1, 2'b11, 1'b0, 32'h00000000, 32'h0,        1, 1'b1, 32'h0,        1'b0, 32'h0);

      foreach (tbl[i]) begin
         run_txn(tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, 1'b0,
                 lat, rd, e, din, n_we, n_re);
         check("tbl_latency", i, lat, tbl[i].lat);
         check("tbl_err", i, {31'b0, e}, {31'b0, tbl[i].err});
         check("tbl_read_strobes", i, n_re, (!tbl[i].err && (!tbl[i].wr || tbl[i].sz != 2'b10)) ? 1 : 0);
         check("tbl_write_strobes", i, n_we, (!tbl[i].err && tbl[i].wr) ? 1 : 0);
         if (tbl[i].chk_rd) check("tbl_rdata", i, rd, tbl[i].rd);
         if (tbl[i].wr && !tbl[i].err) check("tbl_data_in", i, din, tbl[i].din);
      end

      // Reset while the read-modify-write is in its write cycle.
      bus.req_valid = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b01;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h00000008; bus.req_wdata = 32'h00005555;
      @(negedge clk);
      check("abort_rd_phase", 0, {31'b0, read_enable}, 32'd1);
      @(negedge clk);
      check("abort_mrg_phase", 0, {31'b0, write_enable}, 32'd1);
      #1;
      dc = done_cnt;
      nRst = 1'b0;
      #1;
      check("abort_we_drop", 0, {31'b0, write_enable}, 32'd0);
      check("abort_idle", 0, {30'b0, bus.busy, bus.req_ready}, 32'd1);
      check("abort_rdata", 0, bus.rdata, 32'h0);
      check("abort_data_in", 0, data_in, 32'h0);
      bus.req_valid = 1'b0;
      repeat (2) @(negedge clk);
      nRst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("abort_ram_kept", 2, mem[2], 32'h11EE3344);
      check("abort_no_done", 0, done_cnt - dc, 0);

      // Randomized traffic against the word-array model.
      for (int i = 0; i < 16; i++) begin
         w = $urandom;
         ref_mem[i] = w;
         poke(i, w);
      end
      last_load = 32'h0;
      for (int t = 0; t < 200; t++) begin
         wr   = 1'($urandom_range(0, 1));
         sh   = $urandom_range(0, 9);
         sz   = (sh < 8) ? 2'(sh % 3) : 2'b11;
         uns  = 1'($urandom_range(0, 1));
         addr = $urandom;
         wd   = $urandom;
         drop = ($urandom_range(0, 3) == 0);
         a    = addr[5:0];
         bad  = (sz == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
         bad  = bad || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`endif
         erd = 32'h0;
         if (bad) begin
            elat = 1; eerr = 1'b1; erd = last_load;
         end else if (!wr) begin
            elat = 2; eerr = 1'b0;
            w = ref_mem[a[5:2]];
            case (sz)
               2'b00: begin
                  sh = 8 * a[1:0];
                  v = (w >> sh) & 32'hFF;
                  if (!uns && v[7]) v = v | 32'hFFFFFF00;
               end
               2'b01: begin
                  sh = 16 * a[1];
                  v = (w >> sh) & 32'hFFFF;
                  if (!uns && v[15]) v = v | 32'hFFFF0000;
               end
               default: v = w;
            endcase
            last_load = v;
            erd = v;
         end else begin
            eerr = 1'b0;
            if (sz == 2'b10) begin
               elat = 2;
               ref_mem[a[5:2]] = wd;
            end else begin
               elat = 3;
               sh = (sz == 2'b00) ? 8 * a[1:0] : 16 * a[1];
               m  = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
               ref_mem[a[5:2]] = (ref_mem[a[5:2]] & ~m) | ((wd << sh) & m);
            end
         end
         run_txn(wr, sz, uns, addr, wd, drop, lat, rd, e, din, n_we, n_re);
         check("rnd_latency", t, lat, elat);
         check("rnd_err", t, {31'b0, e}, {31'b0, eerr});
         if (bad || !wr) check("rnd_rdata", t, rd, erd);
      end
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 16; i++) check("rnd_ram_word", i, mem[i], ref_mem[i]);

      check("strobes_overlap", 0, both_hi, 0);
      check("done_back_to_back", 0, dbl_done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 6, is the width of the byte address presented to the word RAM.
REQ-002 Parameter RESP_HOLD, default 1, means rdata holds its last load result until the next load completes; 0 means rdata reads 0 outside the done cycle.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 nRst  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  core requests an access; held high until done.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-008 req_unsigned  in  1  zero-extend loads (LBU/LHU) when 1, sign-extend when 0.
REQ-009 req_addr  in  32  byte address from the ALU.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 req_ready  out  1  high in IDLE only; the request is accepted on the edge where req_valid & req_ready.
REQ-012 done  out  1  single-cycle completion pulse.
REQ-013 err  out  1  single-cycle pulse with done for an illegal or misaligned request.
REQ-014 rdata  out  32  formatted load result.
REQ-015 busy  out  1  state != IDLE; the core uses it to stall the PC.
REQ-016 write_enable, read_enable  out  1 each  drive the RAM strobes.
REQ-017 address_DM  out  ADDR_W  is the word-aligned byte address (captured addr[ADDR_W-1:2], 2'b00).
REQ-018 data_in  out  32  is the RAM write word.
REQ-019 data_out  in  32  is the RAM read word, registered by the RAM and valid the cycle after read_enable with a stable address.

Function
REQ-020 Accept captures addr, size, write, unsigned, and wdata into internal registers; RAM-side outputs derive only from captured values.
REQ-021 The FSM states are IDLE, RD, MRG, WR, and RESP; encoding is free.
REQ-022 Load path: IDLE->RD (read_enable=1)->RESP (done=1, rdata formatted from data_out)->IDLE; done is in the 2nd cycle after accept.
REQ-023 Word store path: IDLE->WR (write_enable=1, data_in=wdata)->RESP->IDLE.
REQ-024 Byte/half store path: IDLE->RD->MRG (write_enable=1, data_in=data_out with the addressed lane(s) replaced)->RESP->IDLE; this read-modify-write completes in 3 cycles after accept.
REQ-025 Lane select: a byte uses addr[1:0] lane 0..3 (little-endian); a half uses addr[1] lane 0/1.
REQ-026 Loads sign- or zero-extend the selected lane to 32 bits per req_unsigned; word loads ignore req_unsigned.
REQ-027 write_enable and read_enable are never high in the same cycle, and both are 0 in IDLE and RESP.
REQ-028 req_size=11 is accepted, performs no RAM access, and goes IDLE->RESP with done=1 and err=1.
REQ-029 done is never asserted in consecutive cycles; a new request is accepted at the earliest in the cycle after RESP.
REQ-030 req_valid deasserted mid-transaction is ignored; the transaction completes.
REQ-031 Address bits above ADDR_W-1 are ignored (wrap-around within RAM).

Reset
REQ-032 Asserting nRst=0 asynchronously forces IDLE and clears done, err, write_enable, read_enable, data_in, address_DM, and rdata to 0.
REQ-033 Reset during MRG or WR aborts with no write issued after reset assertion; no done is produced for the aborted request.

Configuration
REQ-034 With DMEM_MISALIGN_TRAP_EN defined, a misaligned half (addr[0]=1) or word (addr[1:0]!=0) access makes no RAM access, goes IDLE->RESP, and pulses done and err.
REQ-035 Without DMEM_MISALIGN_TRAP_EN, misaligned low bits are masked (half: addr[0]=0; word: addr[1:0]=0), the access proceeds normally, and err pulses only for size 11.

Verification
REQ-036 RAM word 3=0x8899AABB, LB addr 0x0D -> done in cycle 2, rdata=0xFFFFFFAA; LBU -> 0x000000AA.
REQ-037 RAM word 2=0x11223344, SB addr 0x0A wdata 0x000000EE -> write_enable in cycle 2, data_in=0x11EE3344, done in cycle 3.
REQ-038 SW addr 0x0C wdata 0xDEADBEEF then LW 0x0C -> rdata=0xDEADBEEF; read_enable and write_enable are never both high.
REQ-039 LH addr 0x0E on word 0x8001_0000 -> rdata=0xFFFF8001; LHU -> 0x00008001.
REQ-040 LW addr 0x06 -> with DMEM_MISALIGN_TRAP_EN: done=err=1 in cycle 1, no strobes; without it: reads word 1, err=0.
REQ-041 SH accepted and nRst pulsed low in MRG -> write_enable drops immediately, RAM unchanged, FSM in IDLE, no done.
